// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one downstream memory req/gnt/rvalid port between the program-fetch
//   master (prog_*) and the load/store master (data_*). Round-robin arbitration,
//   one transaction in flight at a time, with a watchdog that retires
//   transactions whose rvalid never arrives.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   prog_req_i/addr_i          fetch request in
//   prog_gnt_o/rvalid_o/rdata_o  fetch handshake out
//   data_req_i/we_i/addr_i/wdata_i/be_i  load/store request in
//   data_gnt_o/rvalid_o/rdata_o  load/store handshake out
//   mem_req_o/we_o/addr_o/wdata_o/be_o   downstream request out
//   mem_gnt_i/rvalid_i/rdata_i           downstream handshake in
//   err_o                      sticky: watchdog timeout or unsolicited rvalid
module mem_port_arbiter #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TRANSFER_WIDTH = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      prog_req_i,
  input  logic [MEM_ADDR_WIDTH-1:0] prog_addr_i,
  output logic                      prog_gnt_o,
  output logic                      prog_rvalid_o,
  output logic [DATA_WIDTH-1:0]     prog_rdata_o,
  input  logic                      data_req_i,
  input  logic                      data_we_i,
  input  logic [MEM_ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0]     data_wdata_i,
  input  logic [TRANSFER_WIDTH-1:0] data_be_i,
  output logic                      data_gnt_o,
  output logic                      data_rvalid_o,
  output logic [DATA_WIDTH-1:0]     data_rdata_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [TRANSFER_WIDTH-1:0] mem_be_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  output logic                      err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  typedef enum logic {SIDE_DATA, SIDE_PROG} side_e;

  state_e           state_q;
  side_e            last_q;
  side_e            owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  side_e                 winner;
  side_e                 sel_side;
  logic                  sel_req;
  logic                  grant;
  logic                  timeout;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;

  // Arbitration and request forwarding. Everything is gated by rst so that a
  // reset cycle never emits a grant or a response from the old state.
  always_comb begin
    if (prog_req_i && data_req_i)
      winner = (last_q == SIDE_PROG) ? SIDE_DATA : SIDE_PROG;
    else
      winner = prog_req_i ? SIDE_PROG : SIDE_DATA;

    sel_side = owner_q;
    sel_req  = 1'b0;
    case (state_q)
      IDLE: begin
        sel_side = winner;
        sel_req  = prog_req_i | data_req_i;
      end
      REQ: begin
        sel_side = owner_q;
        sel_req  = (owner_q == SIDE_PROG) ? prog_req_i : data_req_i;
      end
      default: sel_req = 1'b0;
    endcase
    if (rst) sel_req = 1'b0;

    mem_req_o   = sel_req;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (sel_req) begin
      if (sel_side == SIDE_PROG) begin
        mem_addr_o = prog_addr_i;
        mem_be_o   = '1;
      end else begin
        mem_we_o    = data_we_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
        mem_be_o    = data_be_i;
      end
    end

    grant      = sel_req & mem_gnt_i;
    prog_gnt_o = grant & (sel_side == SIDE_PROG);
    data_gnt_o = grant & (sel_side == SIDE_DATA);

    // A real response takes priority over the watchdog in the same cycle.
    timeout    = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    resp_valid = (state_q == WAIT) & ~rst & (mem_rvalid_i | timeout);
    resp_data  = mem_rvalid_i ? mem_rdata_i : '0;

    prog_rvalid_o = resp_valid & (owner_q == SIDE_PROG);
    data_rvalid_o = resp_valid & (owner_q == SIDE_DATA);
    prog_rdata_o  = prog_rvalid_o ? resp_data : '0;
    data_rdata_o  = data_rvalid_o ? resp_data : '0;
  end

  assign err_o = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= SIDE_PROG;
      owner_q <= SIDE_PROG;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_rvalid_i) err_q <= 1'b1;
          if (sel_req) begin
            owner_q <= winner;
            if (mem_gnt_i) begin
              last_q  <= winner;
              cnt_q   <= '0;
              state_q <= WAIT;
            end else begin
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_rvalid_i) err_q <= 1'b1;
          if (!sel_req) begin
            state_q <= IDLE;
          end else if (mem_gnt_i) begin
            last_q  <= owner_q;
            cnt_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            state_q <= IDLE;
          end else if (timeout) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_req_i;
  logic [9:0]  prog_addr_i;
  logic        prog_gnt_o, prog_rvalid_o;
  logic [31:0] prog_rdata_o;
  logic        data_req_i, data_we_i;
  logic [9:0]  data_addr_i;
  logic [31:0] data_wdata_i;
  logic [3:0]  data_be_i;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        side;  // 1 = fetch, 0 = data
    logic [31:0] data;
  } resp_t;
  resp_t exp_q[$];

  mem_port_arbiter #(
    .MEM_ADDR_WIDTH(10),
    .DATA_WIDTH(32),
    .TRANSFER_WIDTH(4),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk(clk), .rst(rst),
    .prog_req_i(prog_req_i), .prog_addr_i(prog_addr_i),
    .prog_gnt_o(prog_gnt_o), .prog_rvalid_o(prog_rvalid_o), .prog_rdata_o(prog_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    prog_req_i = 0; prog_addr_i = '0;
    data_req_i = 0; data_we_i = 0; data_addr_i = '0; data_wdata_i = '0; data_be_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    n_cmp++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !== '0) begin
      n_err++;
      $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h be=%h, want all 0",
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o);
    end
    n_cmp++;
    if ({prog_gnt_o, prog_rvalid_o, data_gnt_o, data_rvalid_o, err_o} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_hs: pg=%b pv=%b dg=%b dv=%b err=%b, want 0",
               prog_gnt_o, prog_rvalid_o, data_gnt_o, data_rvalid_o, err_o);
    end
    n_cmp++;
    if ({prog_rdata_o, data_rdata_o} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_rdata: prog=%h data=%h, want 0", prog_rdata_o, data_rdata_o);
    end
    tick();
  endtask

  task automatic test_fetch_zero_wait();
    resp_t e;
    prog_req_i = 1; prog_addr_i = 10'h010; mem_gnt_i = 1;
    #2;
    n_cmp++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, prog_gnt_o, data_gnt_o} !==
        {1'b1, 1'b0, 10'h010, 32'h0, 4'hF, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL fetch_req: req=%b we=%b addr=%h wdata=%h be=%h pg=%b dg=%b, want 1 0 010 0 f 1 0",
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, prog_gnt_o, data_gnt_o);
    end
    tick();
    prog_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0013;
    exp_q.push_back('{1'b1, 32'h0000_0013});
    #2;
    e = exp_q.pop_front();
    n_cmp++;
    if ({prog_rvalid_o, data_rvalid_o, prog_rdata_o, data_rdata_o, mem_req_o} !==
        {e.side, ~e.side, e.data, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL fetch_resp: pv=%b dv=%b prd=%h drd=%h mreq=%b, want pv=1 prd=%h",
               prog_rvalid_o, data_rvalid_o, prog_rdata_o, data_rdata_o, mem_req_o, e.data);
    end
    tick();
    mem_rvalid_i = 0;
  endtask

  task automatic test_round_robin();
    resp_t e;
    logic  exp_side;
    prog_req_i = 1; prog_addr_i = 10'h020;
    data_req_i = 1; data_we_i = 1; data_addr_i = 10'h3FC; data_wdata_i = 32'hCAFE_BABE; data_be_i = 4'h3;
    exp_side = 0;
    for (int i = 0; i < 4; i++) begin
      mem_gnt_i = 1; mem_rvalid_i = 0;
      #2;
      n_cmp++;
      if (exp_side == 0) begin
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, data_gnt_o, prog_gnt_o} !==
            {1'b1, 1'b1, 10'h3FC, 32'hCAFE_BABE, 4'h3, 1'b1, 1'b0}) begin
          n_err++;
          $display("FAIL rr_grant%0d: we=%b addr=%h wdata=%h be=%h dg=%b pg=%b, want data store",
                   i, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, data_gnt_o, prog_gnt_o);
        end
      end else begin
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, data_gnt_o, prog_gnt_o} !==
            {1'b1, 1'b0, 10'h020, 32'h0, 4'hF, 1'b0, 1'b1}) begin
          n_err++;
          $display("FAIL rr_grant%0d: we=%b addr=%h wdata=%h be=%h dg=%b pg=%b, want fetch",
                   i, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, data_gnt_o, prog_gnt_o);
        end
      end
      tick();
      mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1000 + i;
      exp_q.push_back('{exp_side, 32'h1000 + i});
      #2;
      e = exp_q.pop_front();
      n_cmp++;
      if ({prog_rvalid_o, data_rvalid_o} !== {e.side, ~e.side} ||
          (e.side ? prog_rdata_o : data_rdata_o) !== e.data ||
          (e.side ? data_rdata_o : prog_rdata_o) !== 32'h0) begin
        n_err++;
        $display("FAIL rr_resp%0d: pv=%b dv=%b prd=%h drd=%h, want side=%b data=%h",
                 i, prog_rvalid_o, data_rvalid_o, prog_rdata_o, data_rdata_o, e.side, e.data);
      end
      tick();
      exp_side = ~exp_side;
    end
    clear_inputs();
  endtask

  task automatic test_delayed_gnt();
    resp_t e;
    data_req_i = 1; data_we_i = 0; data_addr_i = 10'h100; data_be_i = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin prog_req_i = 1; prog_addr_i = 10'h044; end
      mem_gnt_i = (c == 3);
      #2;
      n_cmp++;
      if ({mem_req_o, mem_addr_o, data_gnt_o, prog_gnt_o} !== {1'b1, 10'h100, (c == 3), 1'b0}) begin
        n_err++;
        $display("FAIL dly_cycle%0d: mreq=%b addr=%h dg=%b pg=%b, want 1 100 %0d 0",
                 c, mem_req_o, mem_addr_o, data_gnt_o, prog_gnt_o, (c == 3));
      end
      tick();
    end
    data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_0001;
    exp_q.push_back('{1'b0, 32'hDEAD_0001});
    #2;
    e = exp_q.pop_front();
    n_cmp++;
    if ({data_rvalid_o, prog_rvalid_o, data_rdata_o, mem_req_o, prog_gnt_o} !==
        {~e.side, e.side, e.data, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL dly_resp: dv=%b pv=%b drd=%h mreq=%b pg=%b, want 1 0 %h 0 0",
               data_rvalid_o, prog_rvalid_o, data_rdata_o, mem_req_o, prog_gnt_o, e.data);
    end
    tick();
    mem_rvalid_i = 0; mem_gnt_i = 1;
    #2;
    n_cmp++;
    if ({mem_req_o, mem_addr_o, prog_gnt_o, data_gnt_o} !== {1'b1, 10'h044, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL dly_fetch: mreq=%b addr=%h pg=%b dg=%b, want 1 044 1 0",
               mem_req_o, mem_addr_o, prog_gnt_o, data_gnt_o);
    end
    tick();
    prog_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0A0A;
    exp_q.push_back('{1'b1, 32'h0000_0A0A});
    #2;
    e = exp_q.pop_front();
    n_cmp++;
    if ({prog_rvalid_o, prog_rdata_o, data_rvalid_o} !== {e.side, e.data, 1'b0}) begin
      n_err++;
      $display("FAIL dly_fetch_resp: pv=%b prd=%h dv=%b, want 1 %h 0",
               prog_rvalid_o, prog_rdata_o, data_rvalid_o, e.data);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout();
    resp_t e;
    int    waited;
    bit    seen;
    prog_req_i = 1; prog_addr_i = 10'h0C0; mem_gnt_i = 1;
    tick();
    prog_req_i = 0; mem_gnt_i = 0;
    exp_q.push_back('{1'b1, 32'h0});
    waited = 0; seen = 0;
    while (!seen && waited < 40) begin
      waited++;
      #2;
      if (prog_rvalid_o || data_rvalid_o) seen = 1;
      else tick();
    end
    n_cmp++;
    if (!seen || waited != 16) begin
      n_err++;
      $display("FAIL to_latency: seen=%b wait_cycle=%0d, want rvalid in wait cycle 16", seen, waited);
    end
    if (seen) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({prog_rvalid_o, data_rvalid_o, prog_rdata_o, err_o} !== {e.side, ~e.side, e.data, 1'b0}) begin
        n_err++;
        $display("FAIL to_resp: pv=%b dv=%b prd=%h err=%b, want 1 0 0 0",
                 prog_rvalid_o, data_rvalid_o, prog_rdata_o, err_o);
      end
      tick();
    end else begin
      void'(exp_q.pop_front());
    end
    #2;
    n_cmp++;
    if (err_o !== 1'b1) begin
      n_err++;
      $display("FAIL to_err: err=%b, want 1", err_o);
    end
    data_req_i = 1; data_we_i = 0; data_addr_i = 10'h200; data_be_i = 4'hF; mem_gnt_i = 1;
    #1;
    n_cmp++;
    if ({data_gnt_o, mem_addr_o} !== {1'b1, 10'h200}) begin
      n_err++;
      $display("FAIL to_next_gnt: dg=%b addr=%h, want 1 200", data_gnt_o, mem_addr_o);
    end
    tick();
    data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0055;
    exp_q.push_back('{1'b0, 32'h0000_0055});
    #2;
    e = exp_q.pop_front();
    n_cmp++;
    if ({data_rvalid_o, data_rdata_o, err_o} !== {~e.side, e.data, 1'b1}) begin
      n_err++;
      $display("FAIL to_next_resp: dv=%b drd=%h err=%b, want 1 %h 1",
               data_rvalid_o, data_rdata_o, err_o, e.data);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_unsolicited();
    do_reset();
    #2;
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_err++;
      $display("FAIL uns_err_clear: err=%b, want 0", err_o);
    end
    mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0BAD;
    #1;
    n_cmp++;
    if ({prog_rvalid_o, data_rvalid_o, prog_rdata_o, data_rdata_o} !== '0) begin
      n_err++;
      $display("FAIL uns_route: pv=%b dv=%b prd=%h drd=%h, want all 0",
               prog_rvalid_o, data_rvalid_o, prog_rdata_o, data_rdata_o);
    end
    tick();
    mem_rvalid_i = 0;
    #2;
    n_cmp++;
    if (err_o !== 1'b1) begin
      n_err++;
      $display("FAIL uns_err: err=%b, want 1", err_o);
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    prog_req_i = 1; prog_addr_i = 10'h0AA; mem_gnt_i = 1;
    tick();
    prog_req_i = 0; mem_gnt_i = 0; rst = 1;
    #2;
    n_cmp++;
    if ({prog_rvalid_o, data_rvalid_o, mem_req_o} !== 3'b0) begin
      n_err++;
      $display("FAIL rstw_rst_cycle: pv=%b dv=%b mreq=%b, want 0", prog_rvalid_o, data_rvalid_o, mem_req_o);
    end
    tick();
    rst = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0077;
    #2;
    n_cmp++;
    if ({prog_rvalid_o, data_rvalid_o, prog_rdata_o, data_rdata_o, err_o} !== '0) begin
      n_err++;
      $display("FAIL rstw_late: pv=%b dv=%b prd=%h drd=%h err=%b, want all 0",
               prog_rvalid_o, data_rvalid_o, prog_rdata_o, data_rdata_o, err_o);
    end
    tick();
    mem_rvalid_i = 0;
    #2;
    n_cmp++;
    if ({err_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, prog_gnt_o, data_gnt_o} !==
        {1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rstw_after: err=%b mreq=%b we=%b addr=%h wdata=%h be=%h, want err=1 rest 0",
               err_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o);
    end
    tick();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_fetch_zero_wait();
    test_round_robin();
    test_delayed_gnt();
    test_timeout();
    test_unsolicited();
    test_reset_in_wait();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d responses never seen, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
